reg_file_wb: RTL and testbench
==============================

Name: reg_file_wb

Overview:
- Register file for the 3-bit register address space, 8 x W bits, with one write port and two read ports.
- Sits at the consuming end of the write-address selection path; the MUX_2 output Reg_write_ad drives the write port directly.
- Includes an issue/writeback scoreboard so decode stalls on a read-after-write hazard.
- Includes write-to-read bypass, so the writeback cycle itself never stalls.

Parameters:
- N, 3, register address width; register count is 2**N.
- W, 16, data width.
- LINK_REG, 7, address written by link-type instructions; it has no special storage behaviour here and exists for scoreboard tests.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- rs_ad  input  N  read port A address.
- rt_ad  input  N  read port B address.
- rs_data  output  W  read port A data, combinational.
- rt_data  output  W  read port B data, combinational.
- Reg_write_ad  input  N  writeback destination address.
- Reg_write_data  input  W  writeback data.
- Reg_write_en  input  1  writeback strobe.
- issue_en  input  1  an instruction with a destination is issuing this cycle.
- issue_ad  input  N  destination of the issuing instruction.
- stall  output  1  hazard on rs_ad or rt_ad; decode must hold.
- pending  output  2**N  per-register busy bits (bit 0 always 0).
- wb_orphan  output  1  sticky error: writeback to a register that was not pending.

Behaviour:
- Reset (async, rst=1):
  - All registers = 0, pending = 0, wb_orphan = 0.
  - stall is therefore 0 and read data is 0.
  - Clears immediately, mid-operation included; the first edge after rst falls behaves as if from power-up.
- Register 0:
  - Reads always return 0.
  - Writes to address 0 are discarded.
  - Never pending, never causes stall, never sets wb_orphan.
- Write: on a rising edge with Reg_write_en=1 and Reg_write_ad!=0, reg[Reg_write_ad] <= Reg_write_data.
- Read: rs_data = 0 if rs_ad==0; else Reg_write_data if Reg_write_en && Reg_write_ad==rs_ad (bypass); else reg[rs_ad]. rt_data follows the same rule. Latency is zero.
- Scoreboard:
  - Set: issue_en=1 && issue_ad!=0 && stall=0 sets pending[issue_ad] at the edge.
  - issue_en is ignored while stall=1.
  - Clear: Reg_write_en=1 && Reg_write_ad!=0 clears pending[Reg_write_ad] at the edge.
  - Same address set and clear in one cycle: the set wins (new producer supersedes the old one); pending stays 1.
  - Different addresses in one cycle: both take effect.
  - Re-issue to an already-pending address: pending stays 1; no counting (single outstanding producer per register).
- stall (combinational):
  - Port A hazard: rs_ad!=0 && pending[rs_ad] && !(Reg_write_en && Reg_write_ad==rs_ad).
  - Port B hazard: the same expression on rt_ad.
  - stall = port A hazard OR port B hazard.
  - A writeback arriving in the same cycle resolves the hazard via bypass.
- wb_orphan: set at the edge when Reg_write_en=1, Reg_write_ad!=0 and pending[Reg_write_ad]=0. Only rst clears it. The write itself still occurs.
- No X propagation: all state is reset, and all read paths are defined for every address.

Decomposition:
- Shared package reg_pkg holds:
  - constants REG_AD_W=3, DATA_W=16, ZERO_REG=0, LINK_REG=7, NUM_REGS=8;
  - typedefs reg_ad_t and data_t.
- The existing MUX_2 selector constant 7 is to move to LINK_REG in this package.
- One natural sub-module, reg_scoreboard, containing:
  - the pending vector, issue/clear logic, stall generation and wb_orphan;
  - the storage array and bypass muxes stay in reg_file_wb.

Test Plan:
- Reset: during operation assert rst with reg[3]=0xBEEF and pending[3]=1 → same cycle rs_data(rs_ad=3)=0, pending=0, stall=0, wb_orphan=0.
- Write/read and bypass:
  - Write 0x1234 to addr 5, then read rs_ad=5 → 0x1234 on the next cycle.
  - Same cycle, write 0xABCD to addr 5 with rt_ad=5 → rt_data=0xABCD before the edge.
- Register 0: write 0xFFFF to addr 0, read rs_ad=0 → 0; issue_ad=0 → pending stays 0; no stall, no wb_orphan.
- Hazard and release:
  - Issue to addr 7 (LINK_REG), next cycle rs_ad=7 → stall=1; issue_en=1 to addr 2 in that cycle is ignored (pending[2] stays 0).
  - Writeback to 7 with 0x0042 → stall=0 in that cycle and rs_data=0x0042; pending[7]=0 after the edge.
- Simultaneous set/clear: pending[4]=1, same cycle issue_ad=4 and writeback to 4 → pending[4]=1 after the edge, wb_orphan=0.
- Orphan writeback: writeback to addr 6 with pending[6]=0 → reg[6] updated, wb_orphan=1 and stays 1 through later clean writebacks until rst.

Source files
------------

// File: rtl/reg_pkg.sv
// Shared constants and types for the 8-entry register file and its users
// (including the write-address MUX_2, whose link selector lives here now).
package reg_pkg;
    localparam int REG_AD_W = 3;
    localparam int DATA_W   = 16;
    localparam int ZERO_REG = 0;
    localparam int LINK_REG = 7;
    localparam int NUM_REGS = 8;

    typedef logic [REG_AD_W-1:0] reg_ad_t;
    typedef logic [DATA_W-1:0]   data_t;
endpackage

// File: rtl/reg_scoreboard.sv
// Issue/writeback scoreboard: one busy bit per register, read-after-write
// stall generation, and a sticky flag for writebacks nobody was waiting on.
module reg_scoreboard
    import reg_pkg::*;
#(
    parameter int N = REG_AD_W
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N-1:0]    rs_ad,
    input  logic [N-1:0]    rt_ad,
    input  logic            wr_en,
    input  logic [N-1:0]    wr_ad,
    input  logic            issue_en,
    input  logic [N-1:0]    issue_ad,
    output logic            stall,
    output logic [2**N-1:0] pending,
    output logic            wb_orphan
);
    logic            wb_hit;
    logic            issue_ok;
    logic            haz_a;
    logic            haz_b;
    logic [2**N-1:0] pending_nxt;

    // Hazards: a busy source stalls unless its producer writes back this
    // cycle, in which case the bypass path supplies the value.
    always_comb begin
        wb_hit   = wr_en && (wr_ad != '0);
        haz_a    = (rs_ad != '0) && pending[rs_ad] && !(wr_en && (wr_ad == rs_ad));
        haz_b    = (rt_ad != '0) && pending[rt_ad] && !(wr_en && (wr_ad == rt_ad));
        stall    = haz_a || haz_b;
        issue_ok = issue_en && (issue_ad != '0) && !stall;
    end

    // Next busy vector: clear first, then set, so a new producer issued in
    // the same cycle as the old one's writeback keeps the register busy.
    always_comb begin
        pending_nxt = pending;
        if (wb_hit)
            pending_nxt[wr_ad] = 1'b0;
        if (issue_ok)
            pending_nxt[issue_ad] = 1'b1;
        pending_nxt[0] = 1'b0;
    end

    // Busy bits and the sticky orphan-writeback flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending   <= '0;
            wb_orphan <= 1'b0;
        end else begin
            pending <= pending_nxt;
            if (wb_hit && !pending[wr_ad])
                wb_orphan <= 1'b1;
        end
    end
endmodule

// File: rtl/reg_file_wb.sv
// 2**N x W register file, one write port and two zero-latency read ports
// with write-to-read bypass; register 0 is hardwired to zero.
module reg_file_wb
    import reg_pkg::*;
#(
    parameter int N        = REG_AD_W,
    parameter int W        = DATA_W,
    parameter int LINK_REG = reg_pkg::LINK_REG
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N-1:0]    rs_ad,
    input  logic [N-1:0]    rt_ad,
    output logic [W-1:0]    rs_data,
    output logic [W-1:0]    rt_data,
    input  logic [N-1:0]    Reg_write_ad,
    input  logic [W-1:0]    Reg_write_data,
    input  logic            Reg_write_en,
    input  logic            issue_en,
    input  logic [N-1:0]    issue_ad,
    output logic            stall,
    output logic [2**N-1:0] pending,
    output logic            wb_orphan
);
    logic [2**N-1:0][W-1:0] regs;

    // The link register is an ordinary register here; just make sure it is
    // addressable and not the zero register.
    if (LINK_REG < 1 || LINK_REG >= 2**N) begin : g_bad_link
        $error("LINK_REG outside register address space");
    end

    // Storage; writes to register 0 are dropped so it stays zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            regs <= '0;
        else if (Reg_write_en && (Reg_write_ad != '0))
            regs[Reg_write_ad] <= Reg_write_data;
    end

    // Read ports: zero register, then same-cycle writeback bypass, then array.
    always_comb begin
        rs_data = regs[rs_ad];
        rt_data = regs[rt_ad];
        if (Reg_write_en && (Reg_write_ad == rs_ad))
            rs_data = Reg_write_data;
        if (Reg_write_en && (Reg_write_ad == rt_ad))
            rt_data = Reg_write_data;
        if (rs_ad == '0)
            rs_data = '0;
        if (rt_ad == '0)
            rt_data = '0;
    end

    reg_scoreboard #(.N(N)) u_sb (
        .clk       (clk),
        .rst       (rst),
        .rs_ad     (rs_ad),
        .rt_ad     (rt_ad),
        .wr_en     (Reg_write_en),
        .wr_ad     (Reg_write_ad),
        .issue_en  (issue_en),
        .issue_ad  (issue_ad),
        .stall     (stall),
        .pending   (pending),
        .wb_orphan (wb_orphan)
    );
endmodule

// File: tb/tb_reg_file_wb.sv
// Directed bench for reg_file_wb: a behavioural register/busy-bit model is
// compared against the DUT every cycle, plus hand-computed literal checks.
module tb_reg_file_wb;
    import reg_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  rs_ad, rt_ad, Reg_write_ad, issue_ad;
    logic [15:0] rs_data, rt_data, Reg_write_data;
    logic        Reg_write_en, issue_en, stall, wb_orphan;
    logic [7:0]  pending;

    int checks = 0;
    int errors = 0;

    reg_file_wb dut (
        .clk            (clk),
        .rst            (rst),
        .rs_ad          (rs_ad),
        .rt_ad          (rt_ad),
        .rs_data        (rs_data),
        .rt_data        (rt_data),
        .Reg_write_ad   (Reg_write_ad),
        .Reg_write_data (Reg_write_data),
        .Reg_write_en   (Reg_write_en),
        .issue_en       (issue_en),
        .issue_ad       (issue_ad),
        .stall          (stall),
        .pending        (pending),
        .wb_orphan      (wb_orphan)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    data_t      mreg [8];
    logic [7:0] mpend;
    logic       morph;

    function automatic data_t m_read(input reg_ad_t ad);
        if (ad == 0) return 16'h0;
        if (Reg_write_en && Reg_write_ad == ad) return Reg_write_data;
        return mreg[ad];
    endfunction

    function automatic logic m_busy(input reg_ad_t ad);
        return (ad != 0) && mpend[ad] && !(Reg_write_en && Reg_write_ad == ad);
    endfunction

    function automatic logic m_stall();
        return m_busy(rs_ad) || m_busy(rt_ad);
    endfunction

    function automatic logic [7:0] m_next_pend();
        logic [7:0] p;
        p = mpend;
        if (Reg_write_en && Reg_write_ad != 0) p[Reg_write_ad] = 1'b0;
        if (issue_en && issue_ad != 0 && !m_stall()) p[issue_ad] = 1'b1;
        return p;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 8; i++) mreg[i] <= 16'h0;
            mpend <= 8'h0;
            morph <= 1'b0;
        end else begin
            if (Reg_write_en && Reg_write_ad != 0) begin
                mreg[Reg_write_ad] <= Reg_write_data;
                if (!mpend[Reg_write_ad]) morph <= 1'b1;
            end
            mpend <= m_next_pend();
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        checks = checks + 5;
        if (rs_data !== m_read(rs_ad)) begin
            errors++; $display("FAIL model_rs_data got %h exp %h", rs_data, m_read(rs_ad));
        end
        if (rt_data !== m_read(rt_ad)) begin
            errors++; $display("FAIL model_rt_data got %h exp %h", rt_data, m_read(rt_ad));
        end
        if (stall !== m_stall()) begin
            errors++; $display("FAIL model_stall got %b exp %b", stall, m_stall());
        end
        if (pending !== mpend) begin
            errors++; $display("FAIL model_pending got %b exp %b", pending, mpend);
        end
        if (wb_orphan !== morph) begin
            errors++; $display("FAIL model_wb_orphan got %b exp %b", wb_orphan, morph);
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic lit(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", nm, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic wen, input logic [2:0] wad, input logic [15:0] wd,
                         input logic ien, input logic [2:0] iad,
                         input logic [2:0] rs, input logic [2:0] rt);
        Reg_write_en = wen; Reg_write_ad = wad; Reg_write_data = wd;
        issue_en = ien; issue_ad = iad; rs_ad = rs; rt_ad = rt;
        #1;
    endtask

    initial begin
        rst = 1'b1;
        Reg_write_en = 0; Reg_write_ad = 0; Reg_write_data = 0;
        issue_en = 0; issue_ad = 0; rs_ad = 0; rt_ad = 0;
        #2;
        lit("reset_pending", {24'h0, pending}, 32'h0);
        lit("reset_orphan", {31'h0, wb_orphan}, 32'h0);
        tick(); tick();
        rst = 1'b0;

        // write then read, plus same-cycle bypass on port B
        drive(0, 0, 16'h0, 1, 5, 0, 0);                      tick();
        drive(1, 5, 16'h1234, 0, 0, 0, 0);                   tick();
        drive(0, 0, 16'h0, 1, 5, 5, 0);
        lit("read_after_write", {16'h0, rs_data}, 32'h1234); tick();
        drive(1, 5, 16'hABCD, 0, 0, 5, 5);
        lit("bypass_rt", {16'h0, rt_data}, 32'hABCD);
        lit("bypass_no_stall", {31'h0, stall}, 32'h0);       tick();

        // register 0 is inert
        drive(1, 0, 16'hFFFF, 1, 0, 0, 0);
        lit("zero_read", {16'h0, rs_data}, 32'h0);           tick();
        drive(0, 0, 16'h0, 0, 0, 0, 0);
        lit("zero_pending", {24'h0, pending}, 32'h0);
        lit("zero_orphan", {31'h0, wb_orphan}, 32'h0);

        // hazard on the link register, issue ignored while stalled
        drive(0, 0, 16'h0, 1, LINK_REG[2:0], 0, 0);          tick();
        drive(0, 0, 16'h0, 1, 2, 7, 0);
        lit("hazard_stall", {31'h0, stall}, 32'h1);          tick();
        lit("ignored_issue", {31'h0, pending[2]}, 32'h0);
        lit("link_pending", {31'h0, pending[7]}, 32'h1);
        drive(1, 7, 16'h0042, 0, 0, 7, 0);
        lit("release_stall", {31'h0, stall}, 32'h0);
        lit("release_data", {16'h0, rs_data}, 32'h0042);     tick();
        drive(0, 0, 16'h0, 0, 0, 0, 0);
        lit("link_cleared", {31'h0, pending[7]}, 32'h0);

        // simultaneous set and clear on one address
        drive(0, 0, 16'h0, 1, 4, 0, 0);                      tick();
        drive(1, 4, 16'h4444, 1, 4, 0, 0);                   tick();
        drive(0, 0, 16'h0, 0, 0, 0, 0);
        lit("set_wins", {31'h0, pending[4]}, 32'h1);
        lit("set_wins_orphan", {31'h0, wb_orphan}, 32'h0);
        drive(1, 4, 16'h4445, 0, 0, 0, 0);                   tick();

        // orphan writeback, sticky through clean writebacks
        drive(1, 6, 16'h6666, 0, 0, 6, 0);                   tick();
        drive(0, 0, 16'h0, 1, 3, 6, 0);
        lit("orphan_write", {16'h0, rs_data}, 32'h6666);
        lit("orphan_set", {31'h0, wb_orphan}, 32'h1);        tick();
        drive(1, 3, 16'hBEEF, 0, 0, 0, 0);                   tick();
        drive(0, 0, 16'h0, 1, 3, 0, 0);
        lit("orphan_sticky", {31'h0, wb_orphan}, 32'h1);     tick();

        // async reset mid-operation with reg[3]=BEEF, pending[3]=1
        drive(0, 0, 16'h0, 0, 0, 3, 0);
        lit("pre_reset_stall", {31'h0, stall}, 32'h1);
        lit("pre_reset_data", {16'h0, rs_data}, 32'hBEEF);
        rst = 1'b1;
        #1;
        lit("rst_data", {16'h0, rs_data}, 32'h0);
        lit("rst_pending", {24'h0, pending}, 32'h0);
        lit("rst_stall", {31'h0, stall}, 32'h0);
        lit("rst_orphan", {31'h0, wb_orphan}, 32'h0);
        tick();
        rst = 1'b0;

        // clean operation after reset
        drive(0, 0, 16'h0, 1, 2, 0, 0);                      tick();
        drive(1, 2, 16'h2222, 0, 0, 0, 0);                   tick();
        drive(0, 0, 16'h0, 0, 0, 2, 3);
        lit("post_rst_read", {16'h0, rs_data}, 32'h2222);
        lit("post_rst_reg3", {16'h0, rt_data}, 32'h0);
        lit("post_rst_orphan", {31'h0, wb_orphan}, 32'h0);
        tick(); tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
